downcount_timer: RTL and testbench
==================================

DOWNCOUNT_TIMER -- requirements
Module: downcount_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port load, input, 1 bit: request to capture load_val into the counter.
REQ-005 SHALL have port load_val, input, WIDTH bits: value written on load.
REQ-006 SHALL have port start, input, 1 bit: request to begin counting down.
REQ-007 SHALL have port pause, input, 1 bit: while high in RUN, the count holds.
REQ-008 SHALL have port stop, input, 1 bit: aborts RUN; the count holds its current value.
REQ-009 SHALL have port count, output, WIDTH bits: current counter value, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while state is RUN, registered.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the count reaches zero, registered.
REQ-012 SHALL have port zero, output, 1 bit: combinational (count == 0).

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN; busy = (state == RUN).
REQ-014 In IDLE, priority SHALL be: load > start. With load=1, count <= load_val and start is ignored that cycle.
REQ-015 In IDLE, start=1 with count != 0 SHALL move the FSM to RUN at that edge; count is unchanged at that edge.
REQ-016 In IDLE, start=1 with count == 0 SHALL stay in IDLE and pulse done for one cycle after that edge.
REQ-017 In RUN, priority SHALL be: stop > pause > decrement; load and start are ignored in RUN.
REQ-018 In RUN with stop=1, the FSM SHALL go to IDLE at that edge, count SHALL hold, and done SHALL stay 0.
REQ-019 In RUN with pause=1 (and stop=0), count and state SHALL hold.
REQ-020 In RUN with pause=0 and stop=0, count SHALL decrement by 1 per edge.
REQ-021 When a decrement takes count from 1 to 0, done SHALL be 1 for exactly the following cycle, and the FSM SHALL go to IDLE (see REQ-027 for the exception).
REQ-022 Latency: after load N (N>0) and start sampled at edge E, count SHALL equal 0 after edge E+N, with done high in cycle E+N (absent pause/stop).
REQ-023 count SHALL never underflow; no decrement occurs at 0.
REQ-024 done SHALL be 0 in every cycle not covered by REQ-016, REQ-021 or REQ-027.

Reset
REQ-025 reset=1 SHALL asynchronously force state=IDLE, count=0, busy=0, done=0 (zero=1), including mid-RUN; the reload register (REQ-027) SHALL clear to 0.
REQ-026 After reset deasserts, the first active edge SHALL obey REQ-014..REQ-016 normally.

Configuration
REQ-027 With macro DOWNCOUNT_AUTO_RELOAD_EN defined:
- a WIDTH-bit reload register captures load_val on every accepted load;
- on a 1->0 transition in RUN, count <= reload register (count does not rest at 0) and the FSM stays in RUN;
- done still pulses one cycle per period; stop is the only exit from RUN;
- a reload value of 0 makes the FSM go to IDLE with done pulsed.
REQ-028 Without DOWNCOUNT_AUTO_RELOAD_EN, no reload register exists and REQ-021 applies unmodified.

Verification
REQ-029 Reset mid-RUN: load 5, start, assert reset after 2 cycles -> count=0, busy=0, done=0 immediately, without waiting for a clock edge.
REQ-030 Basic countdown: load 3, start at edge E -> count 3,2,1,0 after edges E..E+3; done=1 only in cycle E+3; busy=0 after edge E+3.
REQ-031 Pause/stop: load 4, start, pause for 2 cycles after the first decrement -> count holds at 3 for 2 cycles, done arrives 2 cycles late; separately, stop at count=2 -> count=2, busy=0, no done pulse.
REQ-032 Simultaneous events: load=1,start=1 in IDLE with load_val=7 -> count=7, stays IDLE. start with count=0 -> single done pulse, busy stays 0. load during RUN -> ignored.
REQ-033 Wrap width: WIDTH=4, load 15, start -> exactly 15 decrements to 0, no underflow to 15.
REQ-034 With DOWNCOUNT_AUTO_RELOAD_EN: load 2, start, run 7 cycles -> count 2,1,2,1,..., done pulses every 2 cycles, busy stays 1 until stop.

Source files
------------

// File: rtl/downcount_timer.sv
// downcount_timer
//   Loadable down-counter with a two-state (IDLE/RUN) control FSM.
//   In IDLE, load has priority over start. In RUN, stop has priority over
//   pause, and pause has priority over decrement. done pulses for one cycle
//   when the count reaches zero, or when start is requested while the count
//   is already zero.
//
//   Optional feature (macro DOWNCOUNT_AUTO_RELOAD_EN): a reload register
//   captures load_val on every accepted load. When the count would reach
//   zero in RUN, it restarts from the reload value instead, so the timer runs
//   periodically until stop. A reload value of 0 ends the run instead.
//
// Parameters
//   WIDTH     counter width in bits (2..32)
// Ports
//   clk       clock; all state updates on the rising edge
//   reset     asynchronous, active-high reset
//   load      capture load_val into the counter (IDLE only)
//   load_val  value written on load
//   start     begin counting down (IDLE only)
//   pause     hold the count while in RUN
//   stop      leave RUN; the count keeps its current value
//   count     current counter value (registered)
//   busy      high while the FSM is in RUN (registered; direct view of state)
//   done      one-cycle completion pulse (registered)
//   zero      combinational (count == 0)
//
// Control inputs are level-sampled at every rising edge; there is no
// handshake. A request that is not legal in the current state (load or start
// in RUN, pause or stop in IDLE) is ignored, not queued.
module downcount_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count_next;
  logic             done_next;

`ifdef DOWNCOUNT_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_next;
`endif

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
`ifdef DOWNCOUNT_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
`ifdef DOWNCOUNT_AUTO_RELOAD_EN
      reload_q <= reload_next;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        // load wins over start; start only runs a nonzero count
        if (!load && start && (count != '0)) state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (pause) begin
          state_next = RUN;
        end else if (count == '0) begin
          // unreachable in normal operation; leave RUN rather than underflow
          state_next = IDLE;
        end else if (count == ONE) begin
`ifdef DOWNCOUNT_AUTO_RELOAD_EN
          state_next = (reload_q == '0) ? IDLE : RUN;
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath / output next values
  // ---------------------------------------------------------------------
  always_comb begin
    count_next = count;
    done_next  = 1'b0;
`ifdef DOWNCOUNT_AUTO_RELOAD_EN
    reload_next = reload_q;
`endif
    unique case (state)
      IDLE: begin
        if (load) begin
          count_next = load_val;
`ifdef DOWNCOUNT_AUTO_RELOAD_EN
          reload_next = load_val;
`endif
        end else if (start && (count == '0)) begin
          // nothing to count: report completion immediately
          done_next = 1'b1;
        end
      end
      RUN: begin
        if (!stop && !pause && (count != '0)) begin
          if (count == ONE) begin
            done_next = 1'b1;
`ifdef DOWNCOUNT_AUTO_RELOAD_EN
            count_next = reload_q;
`else
            count_next = '0;
`endif
          end else begin
            count_next = count - ONE;
          end
        end
      end
      default: begin
        count_next = count;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign zero = (count == '0);

endmodule

// File: tb/tb_downcount_timer.sv
// Directed testbench for downcount_timer.
//   u_dut  : WIDTH=8, main sequence
//   u_dut4 : WIDTH=4, full-range countdown without underflow
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, so each check sees the result of the edge just taken.
module tb_downcount_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic       stop;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       zero;

  logic       load4;
  logic [3:0] load_val4;
  logic       start4;
  logic [3:0] count4;
  logic       busy4;
  logic       done4;
  logic       zero4;

  int n_checks;
  int n_fail;

  downcount_timer #(.WIDTH(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  downcount_timer #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .load     (load4),
    .load_val (load_val4),
    .start    (start4),
    .pause    (pause),
    .stop     (stop),
    .count    (count4),
    .busy     (busy4),
    .done     (done4),
    .zero     (zero4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] c, input logic b,
                         input logic d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".zero"},  32'(zero),  32'(c == 8'd0));
  endtask

  // load a value from IDLE, then start (leaves inputs idle after the start edge)
  task automatic load_start(input logic [7:0] v);
    load = 1'b1; load_val = v; tick();
    load = 1'b0; start = 1'b1; tick();
    start = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    load4 = 1'b0; load_val4 = '0; start4 = 1'b0;

    // reset state
    tick(); tick();
    chk_out("reset", 8'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // load and start together in IDLE: load wins, stay IDLE
    load = 1'b1; start = 1'b1; load_val = 8'd7; tick();
    load = 1'b0; start = 1'b0;
    chk_out("load_start_same", 8'd7, 1'b0, 1'b0);
    tick();
    chk_out("load_start_hold", 8'd7, 1'b0, 1'b0);

    // stop at count=2: hold count, no done
    load_start(8'd5);
    chk_out("stop_e", 8'd5, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk_out("stop_pre", 8'd2, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("stop_edge", 8'd2, 1'b0, 1'b0);
    tick();
    chk_out("stop_after", 8'd2, 1'b0, 1'b0);

    // load during RUN is ignored
    load_start(8'd6);
    chk_out("ldrun_e", 8'd6, 1'b1, 1'b0);
    load = 1'b1; load_val = 8'd9; tick(); load = 1'b0;
    chk_out("ldrun_dec", 8'd5, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("ldrun_stop", 8'd5, 1'b0, 1'b0);

    // reset mid-RUN acts without a clock edge
    load_start(8'd5);
    tick(); tick();
    chk_out("rstrun_pre", 8'd3, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_out("rstrun_async", 8'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // first edge after reset: start with count 0 -> single done pulse
    start = 1'b1; tick(); start = 1'b0;
    chk_out("start0_pulse", 8'd0, 1'b0, 1'b1);
    tick();
    chk_out("start0_after", 8'd0, 1'b0, 1'b0);

`ifdef DOWNCOUNT_AUTO_RELOAD_EN
    // periodic: load 2 -> 2,1,2,1,... done on every reload
    load_start(8'd2);
    chk_out("ar_e", 8'd2, 1'b1, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i % 2 == 1) chk_out("ar_odd", 8'd1, 1'b1, 1'b0);
      else            chk_out("ar_even", 8'd2, 1'b1, 1'b1);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("ar_stop", 8'd1, 1'b0, 1'b0);
    tick();
    chk_out("ar_idle", 8'd1, 1'b0, 1'b0);
`else
    // basic countdown: load 3
    load_start(8'd3);
    chk_out("basic_e", 8'd3, 1'b1, 1'b0);
    tick(); chk_out("basic_e1", 8'd2, 1'b1, 1'b0);
    tick(); chk_out("basic_e2", 8'd1, 1'b1, 1'b0);
    tick(); chk_out("basic_e3", 8'd0, 1'b0, 1'b1);
    tick(); chk_out("basic_e4", 8'd0, 1'b0, 1'b0);

    // pause for 2 cycles after the first decrement
    load_start(8'd4);
    chk_out("pause_e", 8'd4, 1'b1, 1'b0);
    tick(); chk_out("pause_dec1", 8'd3, 1'b1, 1'b0);
    pause = 1'b1;
    tick(); chk_out("pause_h1", 8'd3, 1'b1, 1'b0);
    tick(); chk_out("pause_h2", 8'd3, 1'b1, 1'b0);
    pause = 1'b0;
    tick(); chk_out("pause_dec2", 8'd2, 1'b1, 1'b0);
    tick(); chk_out("pause_dec3", 8'd1, 1'b1, 1'b0);
    tick(); chk_out("pause_done", 8'd0, 1'b0, 1'b1);
    tick(); chk_out("pause_after", 8'd0, 1'b0, 1'b0);

    // WIDTH=4: 15 decrements to 0, no underflow
    load4 = 1'b1; load_val4 = 4'd15; tick();
    load4 = 1'b0; start4 = 1'b1; tick(); start4 = 1'b0;
    chk("w4_e.count", 32'(count4), 32'd15);
    chk("w4_e.busy",  32'(busy4),  32'd1);
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk("w4.count", 32'(count4), 32'(i));
      chk("w4.done",  32'(done4),  32'(i == 0));
    end
    chk("w4_end.busy", 32'(busy4), 32'd0);
    chk("w4_end.zero", 32'(zero4), 32'd1);
    tick();
    chk("w4_hold.count", 32'(count4), 32'd0);
    chk("w4_hold.done",  32'(done4),  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
